wire_monitor: RTL

- Receiving-end companion to the team's net-driving demo blocks.
- Samples an externally driven multi-bit net and synchronises it into the clock domain.
- Detects every value change and queues each change as an event record: old value, new value, timestamp.
- Presents records on a valid/ready stream for a testbench scoreboard or debug reader.

---
 rtl/wire_monitor_if.sv | 14 +
 rtl/wire_monitor.sv | 79 +++++++
 2 files changed

// File: rtl/wire_monitor_if.sv
// wire_monitor_if: valid/ready event-record stream from the monitor to its reader
interface wire_monitor_if #(
    parameter int WIDTH = 3,
    parameter int TS_W  = 8
);
    logic             evt_valid;
    logic             evt_ready;
    logic [WIDTH-1:0] evt_old;
    logic [WIDTH-1:0] evt_new;
    logic [TS_W-1:0]  evt_ts;

    modport master (output evt_valid, evt_old, evt_new, evt_ts, input evt_ready);
    modport slave  (input evt_valid, evt_old, evt_new, evt_ts, output evt_ready);
endinterface

// File: rtl/wire_monitor.sv
// wire_monitor: synchronises an async net, queues each value change as {old, new, ts}
module wire_monitor #(
    parameter int WIDTH = 3,
    parameter int DEPTH = 4,
    parameter int TS_W  = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [WIDTH-1:0]         net_in,
    output logic [WIDTH-1:0]         cur_val,
    wire_monitor_if.master           ev,
    output logic [$clog2(DEPTH):0]   evt_count,
    output logic                     overflow,
    input  logic                     clr_ovf
);
    localparam int AW = $clog2(DEPTH);
    localparam int RW = 2 * WIDTH + TS_W;

    logic [WIDTH-1:0] sync1_q, sync1_d, sync2_q, sync2_d, prev_q, prev_d;
    logic [TS_W-1:0]  ts_q, ts_d;
    logic [RW-1:0]    mem_q [DEPTH];
    logic [RW-1:0]    mem_d [DEPTH];
    logic [AW-1:0]    wr_q, wr_d, rd_q, rd_d, head;
    logic [AW:0]      cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic             chg, full, push, pop, drop;

    // change detection, FIFO bookkeeping and sticky overflow; when empty the head
    // index points at the last popped slot so the outputs hold their last values
    always_comb begin
        chg     = sync2_q != prev_q;
        full    = cnt_q == (AW + 1)'(DEPTH);
        pop     = (cnt_q != '0) && ev.evt_ready;
        push    = chg && (!full || pop);
        drop    = chg && full && !pop;
        sync1_d = net_in;
        sync2_d = sync1_q;
        prev_d  = sync2_q;
        ts_d    = ts_q + 1'b1;
        mem_d   = mem_q;
        if (push) mem_d[wr_q] = {prev_q, sync2_q, ts_q};
        wr_d    = push ? wr_q + 1'b1 : wr_q;
        rd_d    = pop ? rd_q + 1'b1 : rd_q;
        cnt_d   = cnt_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
        ovf_d   = drop | (ovf_q & ~clr_ovf);
        head    = (cnt_q != '0) ? rd_q : rd_q - 1'b1;
    end

    // state registers, asynchronously cleared
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
            prev_q  <= '0;
            ts_q    <= '0;
            mem_q   <= '{default: '0};
            wr_q    <= '0;
            rd_q    <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            prev_q  <= prev_d;
            ts_q    <= ts_d;
            mem_q   <= mem_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
        end
    end

    assign cur_val      = sync2_q;
    assign evt_count    = cnt_q;
    assign overflow     = ovf_q;
    assign ev.evt_valid = cnt_q != '0;
    assign {ev.evt_old, ev.evt_new, ev.evt_ts} = mem_q[head];
endmodule
